// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: single-job streaming wrapper around the shift-and-add multiplier.
// Takes an operand pair over valid/ready, holds it on mult_a/mult_b, pulses mult_start
// for one cycle, waits for mult_end, captures mult_s and presents the product on a
// valid/ready result port until it is consumed.
//
// Build option: define MULT_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYCLES
// cycles; an expired job completes with out_prod = 0 and out_err = 1.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | in_ready high; waiting for an operand pair
//   ISSUE | mult_start high for this one cycle; mult_end is ignored
//   WAIT  | waiting for mult_end (or the timeout, when built in)
//   HOLD  | out_valid high; product held until out_ready
module mult_job_sequencer #(
    parameter int tamano         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [tamano-1:0]     in_a,
    input  logic [tamano-1:0]     in_b,
    output logic                  mult_start,
    output logic [tamano-1:0]     mult_a,
    output logic [tamano-1:0]     mult_b,
    input  logic [2*tamano-1:0]   mult_s,
    input  logic                  mult_end,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*tamano-1:0]   out_prod,
    output logic                  out_err,
    output logic [15:0]           jobs_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t                state_q;
    logic                  start_q;
    logic [tamano-1:0]     a_q;
    logic [tamano-1:0]     b_q;
    logic                  valid_q;
    logic [2*tamano-1:0]   prod_q;
    logic [15:0]           jobs_q;
    logic [15:0]           jobs_d;

    // Consumed-result count wraps naturally at 16 bits.
    assign jobs_d = jobs_q + 16'd1;

`ifdef MULT_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] wait_cnt_q;
    logic          err_q;
    logic          timeout_hit;

    // Last WAIT cycle of the budget: the counter has seen TIMEOUT_CYCLES-1 earlier cycles.
    assign timeout_hit = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // WAIT-cycle counter: cleared while issuing so it starts at zero on WAIT entry.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
        end
    end

    assign out_err = err_q;
`else
    // TIMEOUT_CYCLES has no effect in this build; nothing is elaborated here.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end

    assign out_err = 1'b0;
`endif

    // Job sequencing FSM with registered handshake and operand outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            prod_q  <= '0;
            jobs_q  <= '0;
`ifdef MULT_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        start_q <= 1'b1;
                        state_q <= ST_ISSUE;
`ifdef MULT_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                ST_ISSUE: begin
                    // A stale mult_end from the previous job is deliberately not looked at here.
                    start_q <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mult_end) begin
                        prod_q  <= mult_s;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end
`ifdef MULT_TIMEOUT_EN
                    else if (timeout_hit) begin
                        prod_q  <= '0;
                        valid_q <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= ST_HOLD;
                    end
`endif
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        jobs_q  <= jobs_d;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    start_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign mult_start = start_q;
    assign mult_a     = a_q;
    assign mult_b     = b_q;
    assign out_valid  = valid_q;
    assign out_prod   = prod_q;
    assign jobs_done  = jobs_q;

endmodule
